// File: rtl/trace_nexus_pkg.sv
// Shared record layout, width constants and lane-slicing helpers for the
// retire-trace nexus.
package trace_nexus_pkg;

  localparam int TN_NCH     = 2;
  localparam int TN_DEPTH   = 8;
  localparam int TN_IADDR_W = 40;
  localparam int TN_CAUSE_W = 64;
  localparam int TN_INSN_W  = 32;
  localparam int TN_PRIV_W  = 3;
  localparam int TN_DROP_W  = 16;

  // Record layout at default widths, MSB first. The RTL stores records as a
  // flat vector in exactly this field order so that non-default widths work.
  typedef struct packed {
    logic [TN_IADDR_W-1:0] iaddr;
    logic [TN_INSN_W-1:0]  insn;
    logic [TN_PRIV_W-1:0]  priv;
    logic                  exception;
    logic                  interrupt;
    logic [TN_CAUSE_W-1:0] cause;
    logic [TN_IADDR_W-1:0] tval;
    logic                  lost;
  } trace_rec_t;

  // Flat record width for the given address and cause widths.
  function automatic int rec_width(int iaddr_w, int cause_w);
    return 2 * iaddr_w + TN_INSN_W + TN_PRIV_W + 3 + cause_w;
  endfunction

  // LSB position of lane `lane` in a bus of `w`-bit lanes.
  function automatic int lane_lo(int lane, int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer: up to NCH compacted pushes and one pop per cycle.
// Occupancy is a separate counter so full and empty never alias.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int NCH   = 2,
  parameter int CW    = $clog2(NCH + 1),
  parameter int FW    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*W-1:0]  push_data_i,
  input  logic [CW-1:0]     push_cnt_i,
  input  logic              pop_i,
  output logic [W-1:0]      head_o,
  output logic [FW-1:0]     fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [FW-1:0] fill_q;

  // Storage write: slot j of the compacted vector lands at wr_ptr + j.
  // Entries are not reset; the head is masked while the buffer is empty.
  always_ff @(posedge clock) begin
    for (int j = 0; j < NCH; j++) begin
      if (CW'(j) < push_cnt_i) begin
        mem_q[wr_ptr_q + AW'(j)] <= push_data_i[j*W +: W];
      end
    end
  end

  // Pointers wrap naturally at the power-of-two depth; fill tracks occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop_i);
      fill_q   <= fill_q + FW'(push_cnt_i) - FW'(pop_i);
    end
  end

  assign head_o = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign fill_o = fill_q;

endmodule

// File: rtl/trace_nexus_merge.sv
// Retire-trace nexus: qualifies the commit lanes, compacts them in program
// order and admits them all-or-nothing into the record FIFO, counting drops.
module trace_nexus_merge
  import trace_nexus_pkg::*;
#(
  parameter int NCH     = TN_NCH,
  parameter int DEPTH   = TN_DEPTH,
  parameter int IADDR_W = TN_IADDR_W,
  parameter int CAUSE_W = TN_CAUSE_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*IADDR_W-1:0] in_iaddr,
  input  logic [NCH*32-1:0]      in_insn,
  input  logic [NCH*3-1:0]       in_priv,
  input  logic [NCH-1:0]         in_exception,
  input  logic [NCH-1:0]         in_interrupt,
  input  logic [NCH*CAUSE_W-1:0] in_cause,
  input  logic [NCH*IADDR_W-1:0] in_tval,
  input  logic                   cfg_enable,
  input  logic                   cfg_exc_only,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IADDR_W-1:0]     out_iaddr,
  output logic [31:0]            out_insn,
  output logic [2:0]             out_priv,
  output logic                   out_exception,
  output logic                   out_interrupt,
  output logic [CAUSE_W-1:0]     out_cause,
  output logic [IADDR_W-1:0]     out_tval,
  output logic                   out_lost,
  output logic [15:0]            drop_count,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int REC_W = rec_width(IADDR_W, CAUSE_W);
  localparam int CW    = $clog2(NCH + 1);
  localparam int FW    = $clog2(DEPTH) + 1;
  localparam int DW    = TN_DROP_W;

  localparam int O_TVAL  = 1;
  localparam int O_CAUSE = O_TVAL + IADDR_W;
  localparam int O_INTR  = O_CAUSE + CAUSE_W;
  localparam int O_EXC   = O_INTR + 1;
  localparam int O_PRIV  = O_EXC + 1;
  localparam int O_INSN  = O_PRIV + TN_PRIV_W;
  localparam int O_IADDR = O_INSN + TN_INSN_W;

  logic [NCH-1:0]       qual;
  logic [NCH*REC_W-1:0] comp;
  logic [CW-1:0]        k;
  logic                 pop;
  logic [FW-1:0]        free;
  logic                 admit;
  logic [CW-1:0]        push_cnt;
  logic [REC_W-1:0]     head;
  logic [FW-1:0]        fill_w;
  logic [DW:0]          drop_sum;
  logic [DW-1:0]        drop_d, drop_q;
  logic                 ovf_d, ovf_q;
  logic                 lost_d, lost_q;

  // Lane qualification against the live configuration.
  always_comb begin
    qual = '0;
    for (int i = 0; i < NCH; i++) begin
      qual[i] = in_valid[i] & cfg_enable &
                (~cfg_exc_only | in_exception[i] | in_interrupt[i]);
    end
  end

  // Compaction: qualifying lanes pack into consecutive slots, oldest first.
  // A pending loss marker rides on the first slot only.
  always_comb begin
    comp = '0;
    k    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (qual[i]) begin
        comp[k*REC_W +: REC_W] = {in_iaddr[lane_lo(i, IADDR_W) +: IADDR_W],
                                  in_insn[lane_lo(i, 32) +: 32],
                                  in_priv[lane_lo(i, 3) +: 3],
                                  in_exception[i], in_interrupt[i],
                                  in_cause[lane_lo(i, CAUSE_W) +: CAUSE_W],
                                  in_tval[lane_lo(i, IADDR_W) +: IADDR_W],
                                  (k == '0) & lost_q};
        k = k + CW'(1);
      end
    end
  end

  // Admission: all qualifying lanes fit in the space left after this pop, or none go in.
  always_comb begin
    pop      = out_valid & out_ready;
    free     = FW'(DEPTH) - fill_w + FW'(pop);
    admit    = FW'(k) <= free;
    push_cnt = admit ? k : '0;
    drop_sum = {1'b0, drop_q} + (DW+1)'(k);
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    lost_d   = lost_q;
    if (!admit) begin
      drop_d = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
      ovf_d  = 1'b1;
      lost_d = 1'b1;
    end else if (push_cnt != '0) begin
      lost_d = 1'b0;
    end
  end

  // Loss accounting registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      lost_q <= lost_d;
    end
  end

  trace_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH),
    .NCH   (NCH),
    .CW    (CW),
    .FW    (FW)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_data_i (comp),
    .push_cnt_i  (push_cnt),
    .pop_i       (pop),
    .head_o      (head),
    .fill_o      (fill_w)
  );

  assign out_valid     = fill_w != '0;
  assign fill          = fill_w;
  assign out_iaddr     = head[O_IADDR +: IADDR_W];
  assign out_insn      = head[O_INSN +: TN_INSN_W];
  assign out_priv      = head[O_PRIV +: TN_PRIV_W];
  assign out_exception = head[O_EXC];
  assign out_interrupt = head[O_INTR];
  assign out_cause     = head[O_CAUSE +: CAUSE_W];
  assign out_tval      = head[O_TVAL +: IADDR_W];
  assign out_lost      = head[0];
  assign drop_count    = drop_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_trace_nexus_merge.sv
// Self-checking bench for trace_nexus_merge: directed scenarios plus random
// traffic, compared against a queue-based model of the record stream.
module tb_trace_nexus_merge;

  localparam int NCH = 2;
  localparam int DEPTH = 8;

  logic            clock;
  logic            reset;
  logic [1:0]      in_valid;
  logic [79:0]     in_iaddr;
  logic [63:0]     in_insn;
  logic [5:0]      in_priv;
  logic [1:0]      in_exception, in_interrupt;
  logic [127:0]    in_cause;
  logic [79:0]     in_tval;
  logic            cfg_enable, cfg_exc_only;
  logic            out_valid, out_ready;
  logic [39:0]     out_iaddr;
  logic [31:0]     out_insn;
  logic [2:0]      out_priv;
  logic            out_exception, out_interrupt;
  logic [63:0]     out_cause;
  logic [39:0]     out_tval;
  logic            out_lost;
  logic [15:0]     drop_count;
  logic            overflow;
  logic [3:0]      fill;

  trace_nexus_merge dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_iaddr(in_iaddr), .in_insn(in_insn),
    .in_priv(in_priv), .in_exception(in_exception), .in_interrupt(in_interrupt),
    .in_cause(in_cause), .in_tval(in_tval),
    .cfg_enable(cfg_enable), .cfg_exc_only(cfg_exc_only),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_iaddr(out_iaddr), .out_insn(out_insn), .out_priv(out_priv),
    .out_exception(out_exception), .out_interrupt(out_interrupt),
    .out_cause(out_cause), .out_tval(out_tval), .out_lost(out_lost),
    .drop_count(drop_count), .overflow(overflow), .fill(fill)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [39:0] iaddr;
    logic [31:0] insn;
    logic [2:0]  priv;
    logic        exc;
    logic        intr;
    logic [63:0] cause;
    logic [39:0] tval;
    logic        lost;
  } rec_t;

  rec_t q[$];
  int   m_drop;
  bit   m_ovf;
  bit   m_lostp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit lane_takes(int i);
    return in_valid[i] && cfg_enable &&
           (!cfg_exc_only || in_exception[i] || in_interrupt[i]);
  endfunction

  // Reference: what the next clock edge does to the record queue and counters.
  task automatic model_step();
    int  k;
    int  free;
    bit  pop;
    bit  first;
    rec_t r;
    if (reset) begin
      q.delete();
      m_drop = 0; m_ovf = 0; m_lostp = 0;
      return;
    end
    pop = (q.size() > 0) && out_ready;
    k = 0;
    for (int i = 0; i < NCH; i++) if (lane_takes(i)) k++;
    free = DEPTH - q.size() + int'(pop);
    if (pop) void'(q.pop_front());
    if (k <= free) begin
      first = 1;
      for (int i = 0; i < NCH; i++) begin
        if (lane_takes(i)) begin
          r.iaddr = in_iaddr[i*40 +: 40];
          r.insn  = in_insn[i*32 +: 32];
          r.priv  = in_priv[i*3 +: 3];
          r.exc   = in_exception[i];
          r.intr  = in_interrupt[i];
          r.cause = in_cause[i*64 +: 64];
          r.tval  = in_tval[i*40 +: 40];
          r.lost  = first && m_lostp;
          first = 0;
          q.push_back(r);
        end
      end
      if (k > 0) m_lostp = 0;
    end else begin
      m_drop = (m_drop + k > 65535) ? 65535 : m_drop + k;
      m_ovf = 1;
      m_lostp = 1;
    end
  endtask

  task automatic compare();
    chk("valid", out_valid, q.size() > 0);
    chk("fill", fill, q.size());
    chk("drop_count", drop_count, m_drop);
    chk("overflow", overflow, m_ovf);
    if (q.size() > 0) begin
      chk("iaddr", out_iaddr, q[0].iaddr);
      chk("insn", out_insn, q[0].insn);
      chk("priv", out_priv, q[0].priv);
      chk("exception", out_exception, q[0].exc);
      chk("interrupt", out_interrupt, q[0].intr);
      chk("cause", out_cause, q[0].cause);
      chk("tval", out_tval, q[0].tval);
      chk("lost", out_lost, q[0].lost);
    end else begin
      chk("idle_iaddr", out_iaddr, 0);
      chk("idle_lost", out_lost, 0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic set_lane(input int i, input bit v, input logic [39:0] ia,
                          input bit exc, input bit intr, input logic [63:0] cause);
    logic [63:0] r;
    r = {$urandom, $urandom};
    in_valid[i]           = v;
    in_iaddr[i*40 +: 40]  = ia;
    in_insn[i*32 +: 32]   = r[31:0];
    in_priv[i*3 +: 3]     = r[34:32];
    in_exception[i]       = exc;
    in_interrupt[i]       = intr;
    in_cause[i*64 +: 64]  = cause;
    in_tval[i*40 +: 40]   = {r[63:40], r[15:0]};
  endtask

  task automatic idle_lanes();
    for (int i = 0; i < NCH; i++) set_lane(i, 0, 40'h0, 0, 0, 64'h0);
  endtask

  task automatic drain();
    idle_lanes();
    out_ready = 1;
    repeat (DEPTH + 2) tick();
  endtask

  initial begin
    logic [63:0] r;
    reset = 1; out_ready = 0; cfg_enable = 1; cfg_exc_only = 0;
    in_valid = '0; in_iaddr = '0; in_insn = '0; in_priv = '0;
    in_exception = '0; in_interrupt = '0; in_cause = '0; in_tval = '0;
    tick(); tick();
    chk("reset_fill", fill, 0);
    chk("reset_valid", out_valid, 0);
    reset = 0;

    // Two lanes in one cycle, drained in order.
    out_ready = 1;
    set_lane(0, 1, 40'h1000, 0, 0, 64'h0);
    set_lane(1, 1, 40'h1004, 0, 0, 64'h0);
    tick();
    chk("t1_first", out_iaddr, 40'h1000);
    idle_lanes();
    tick();
    chk("t1_second", out_iaddr, 40'h1004);
    tick();
    chk("t1_empty", fill, 0);

    // Overflow with consumer stalled.
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 1, 40'h2000 + 40'(c * 8), 0, 0, 64'h0);
      set_lane(1, 1, 40'h2004 + 40'(c * 8), 0, 0, 64'h0);
      tick();
    end
    chk("t2_fill", fill, 8);
    chk("t2_drop", drop_count, 2);
    chk("t2_ovf", overflow, 1);
    chk("t2_head_lost", out_lost, 0);
    drain();
    set_lane(0, 1, 40'h3000, 0, 0, 64'h0);
    tick();
    chk("t2_lost_mark", out_lost, 1);
    drain();

    // Lane 1 alone leaves no gap.
    out_ready = 0;
    set_lane(1, 1, 40'h4000, 0, 0, 64'h0);
    tick();
    chk("t3_fill1", fill, 1);
    set_lane(0, 1, 40'h4004, 0, 0, 64'h0);
    set_lane(1, 1, 40'h4008, 0, 0, 64'h0);
    tick();
    chk("t3_fill3", fill, 3);
    drain();

    // Exception-only filter.
    cfg_exc_only = 1;
    out_ready = 0;
    set_lane(0, 1, 40'h5000, 0, 0, 64'h0);
    set_lane(1, 1, 40'h5004, 1, 0, 64'h2);
    tick();
    chk("t4_fill", fill, 1);
    chk("t4_exc", out_exception, 1);
    chk("t4_cause", out_cause, 2);
    cfg_exc_only = 0;
    drain();

    // Full with a pop: one record fits, two do not.
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      set_lane(0, 1, 40'h6000 + 40'(c * 8), 0, 0, 64'h0);
      set_lane(1, 1, 40'h6004 + 40'(c * 8), 0, 0, 64'h0);
      tick();
    end
    out_ready = 1;
    set_lane(0, 1, 40'h6100, 0, 0, 64'h0);
    set_lane(1, 0, 40'h0, 0, 0, 64'h0);
    tick();
    chk("t5_fill_one", fill, 8);
    set_lane(0, 1, 40'h6200, 0, 0, 64'h0);
    set_lane(1, 1, 40'h6204, 0, 0, 64'h0);
    tick();
    chk("t5_fill_two", fill, 7);
    chk("t5_drop", drop_count, 4);
    drain();

    // Reset mid-burst.
    out_ready = 0;
    set_lane(0, 1, 40'h7000, 0, 0, 64'h0);
    set_lane(1, 1, 40'h7004, 0, 0, 64'h0);
    tick(); tick();
    set_lane(1, 0, 40'h0, 0, 0, 64'h0);
    tick();
    chk("t6_fill5", fill, 5);
    idle_lanes();
    reset = 1;
    tick();
    chk("t6_valid", out_valid, 0);
    chk("t6_fill", fill, 0);
    chk("t6_drop", drop_count, 0);
    chk("t6_ovf", overflow, 0);
    reset = 0;

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      r = {$urandom, $urandom};
      out_ready    = (c % 200 < 100) ? (r[1:0] != 2'b00) : (r[1:0] == 2'b00);
      cfg_enable   = r[7:4] != 4'h0;
      cfg_exc_only = r[10:8] == 3'b000;
      for (int i = 0; i < NCH; i++) begin
        set_lane(i, r[12 + i], {r[63:40], r[31:16]} ^ 40'(c), r[20 + i] & r[22],
                 r[24 + i] & r[26], {r[31:0], r[63:32]});
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
